// File: rtl/pll_sup_pkg.sv
// Shared types, default parameters and sizing helper for the PLL lock supervisor.
// The state encoding is visible on o_state, so its values are fixed.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        PLL_RST   = 3'd4,
        FAULT     = 3'd5
    } sup_state_t;

    localparam int DEF_N_DOMAINS     = 3;
    localparam int DEF_STABLE_CYC    = 1024;
    localparam int DEF_TIMEOUT_CYC   = 65536;
    localparam int DEF_RST_PULSE_CYC = 16;
    localparam int DEF_STAGGER_CYC   = 8;
    localparam int DEF_MAX_RETRY     = 3;

    // Width of the shared cycle counter: enough for the longest terminal count, never zero.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Status and PLL-control bundle between the supervisor and the CC_PLL / reset consumers.
interface pll_lock_supervisor_if #(
    parameter int N_DOMAINS = 3,
    parameter int RW        = 2
);
    logic                 i_pll_locked;
    logic                 o_pll_stdy_rst;
    logic [N_DOMAINS-1:0] o_rst_core;
    logic                 o_ready;
    logic                 o_fault;
    logic [RW-1:0]        o_retry_cnt;
    logic [2:0]           o_state;

    modport master (
        input  i_pll_locked,
        output o_pll_stdy_rst, o_rst_core, o_ready, o_fault, o_retry_cnt, o_state
    );

    modport slave (
        output i_pll_locked,
        input  o_pll_stdy_rst, o_rst_core, o_ready, o_fault, o_retry_cnt, o_state
    );
endinterface

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single slowly-changing asynchronous level.
module bit_sync2 (
    input  logic i_clk,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge i_clk) begin
        meta <= d;
        q    <= meta;
    end
endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies PLL lock, releases per-domain resets in staggered order, and retries the PLL
// through its steady-lock reset on lock loss or timeout until a sticky fault is declared.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int N_DOMAINS     = DEF_N_DOMAINS,
    parameter int STABLE_CYC    = DEF_STABLE_CYC,
    parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC,
    parameter int RST_PULSE_CYC = DEF_RST_PULSE_CYC,
    parameter int STAGGER_CYC   = DEF_STAGGER_CYC,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    pll_lock_supervisor_if.master  sup
);
    localparam int RW = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int CW = cnt_width(TIMEOUT_CYC, STABLE_CYC, RST_PULSE_CYC, STAGGER_CYC);
    localparam int DW = ($clog2(N_DOMAINS + 1) < 1) ? 1 : $clog2(N_DOMAINS + 1);

    localparam logic [CW-1:0]        TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]        STABLE_LAST  = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0]        PULSE_LAST   = CW'(RST_PULSE_CYC - 1);
    localparam logic [CW-1:0]        STAGGER_LAST = CW'(STAGGER_CYC - 1);
    localparam logic [RW-1:0]        RETRY_MAX    = RW'(MAX_RETRY);
    localparam logic [DW-1:0]        DOM_ALL      = DW'(N_DOMAINS);
    localparam logic [N_DOMAINS-1:0] ALL_ONES     = '1;
    localparam logic [N_DOMAINS-1:0] BIT0         = N_DOMAINS'(1);

    sup_state_t           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        dom_q, dom_d;
    logic [N_DOMAINS-1:0] rst_core_q, rst_core_d;
    logic                 stdy_q, stdy_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic                 lock_s;
    logic                 lock_fail;

    bit_sync2 u_lock_sync (
        .i_clk (i_clk),
        .d     (sup.i_pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            dom_q      <= '0;
            rst_core_q <= ALL_ONES;
            stdy_q     <= 1'b0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dom_q      <= dom_d;
            rst_core_q <= rst_core_d;
            stdy_q     <= stdy_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
            retry_q    <= retry_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dom_d      = dom_q;
        rst_core_d = rst_core_q;
        stdy_d     = stdy_q;
        ready_d    = ready_q;
        fault_d    = fault_q;
        retry_d    = retry_q;
        lock_fail  = 1'b0;

        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    lock_fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE: begin
                // A lock glitch here is tolerated: requalify without spending a retry.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d    = RELEASE;
                    cnt_d      = '0;
                    dom_d      = DW'(1);
                    rst_core_d = ALL_ONES << 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    lock_fail = 1'b1;
                end else if (dom_q == DOM_ALL) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    retry_d = '0;
                end else if (cnt_q == STAGGER_LAST) begin
                    rst_core_d = rst_core_q & ~(BIT0 << dom_q);
                    dom_d      = dom_q + 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) lock_fail = 1'b1;
            end
            PLL_RST: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = WAIT_LOCK;
                    stdy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // Resets reassert at once on any failure; the retry budget decides pulse vs fault.
        if (lock_fail) begin
            rst_core_d = ALL_ONES;
            ready_d    = 1'b0;
            cnt_d      = '0;
            if (retry_q == RETRY_MAX) begin
                state_d = FAULT;
                fault_d = 1'b1;
            end else begin
                state_d = PLL_RST;
                retry_d = retry_q + 1'b1;
                stdy_d  = 1'b1;
            end
        end
    end

    assign sup.o_pll_stdy_rst = stdy_q;
    assign sup.o_rst_core     = rst_core_q;
    assign sup.o_ready        = ready_q;
    assign sup.o_fault        = fault_q;
    assign sup.o_retry_cnt    = retry_q;
    assign sup.o_state        = state_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench: directed scenarios plus randomized lock traffic against a
// phase/elapsed-time reference model of the supervisor.
module tb_pll_lock_supervisor;
    localparam int N       = 3;
    localparam int STABLE  = 8;
    localparam int TIMEOUT = 32;
    localparam int PULSE   = 4;
    localparam int STAGGER = 2;
    localparam int MAXR    = 3;
    localparam int RW      = 2;

    localparam int P_WAIT = 0, P_STABLE = 1, P_RELEASE = 2, P_RUN = 3, P_PRST = 4, P_FAULT = 5;

    logic clk = 1'b0;
    logic rstn;
    int   n_pass   = 0;
    int   n_checks = 0;
    int   cyc      = 0;

    int   m_phase  = P_WAIT;
    int   m_t      = 0;
    int   m_retry  = 0;
    bit   m_l1     = 1'b0;
    bit   m_l2     = 1'b0;

    always #5 clk = ~clk;

    pll_lock_supervisor_if #(.N_DOMAINS(N), .RW(RW)) sup_if ();

    pll_lock_supervisor #(
        .N_DOMAINS     (N),
        .STABLE_CYC    (STABLE),
        .TIMEOUT_CYC   (TIMEOUT),
        .RST_PULSE_CYC (PULSE),
        .STAGGER_CYC   (STAGGER),
        .MAX_RETRY     (MAXR)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .sup    (sup_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s at cycle %0d: observed %0h, required %0h", tag, cyc, obs, exp);
        end
    endtask

    // A failed lock attempt spends one retry, or faults once the budget is gone.
    task automatic model_fail();
        if (m_retry == MAXR) begin
            m_phase = P_FAULT;
        end else begin
            m_retry++;
            m_phase = P_PRST;
        end
        m_t = 0;
    endtask

    task automatic model_step(input bit rst_n, input bit locked);
        bit ls;
        ls   = m_l2;
        m_l2 = m_l1;
        m_l1 = locked;
        if (!rst_n) begin
            m_phase = P_WAIT;
            m_t     = 0;
            m_retry = 0;
        end else begin
            case (m_phase)
                P_WAIT:    if (ls) begin m_phase = P_STABLE; m_t = 0; end
                           else if (m_t == TIMEOUT - 1) model_fail();
                           else m_t++;
                P_STABLE:  if (!ls) begin m_phase = P_WAIT; m_t = 0; end
                           else if (m_t == STABLE - 1) begin m_phase = P_RELEASE; m_t = 0; end
                           else m_t++;
                P_RELEASE: if (!ls) model_fail();
                           else if (m_t == (N - 1) * STAGGER) begin m_phase = P_RUN; m_retry = 0; end
                           else m_t++;
                P_RUN:     if (!ls) model_fail();
                P_PRST:    if (m_t == PULSE - 1) begin m_phase = P_WAIT; m_t = 0; end
                           else m_t++;
                default:   m_phase = m_phase;
            endcase
        end
    endtask

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] v;
        v = '1;
        if (m_phase == P_RELEASE) v = v << (m_t / STAGGER + 1);
        else if (m_phase == P_RUN) v = '0;
        return v;
    endfunction

    task automatic check_all();
        check("model_rst_core", 32'(sup_if.o_rst_core),     32'(exp_rst()));
        check("model_ready",    32'(sup_if.o_ready),        32'(m_phase == P_RUN));
        check("model_stdy_rst", 32'(sup_if.o_pll_stdy_rst), 32'(m_phase == P_PRST));
        check("model_fault",    32'(sup_if.o_fault),        32'(m_phase == P_FAULT));
        check("model_retry",    32'(sup_if.o_retry_cnt),    32'(m_retry));
        check("model_state",    32'(sup_if.o_state),        32'(m_phase));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rstn, sup_if.i_pll_locked);
        #1;
        cyc++;
        check_all();
    endtask

    initial begin
        int n;
        int hi;
        int len;

        // Reset values
        rstn = 1'b0;
        sup_if.i_pll_locked = 1'b0;
        repeat (3) tick();
        check("reset_state", 32'(sup_if.o_state), 0);
        check("reset_rst_core", 32'(sup_if.o_rst_core), 32'h7);
        check("reset_retry", 32'(sup_if.o_retry_cnt), 0);

        // Clean lock: release staggered by 2 cycles, ready one cycle after the last bit
        rstn = 1'b1;
        sup_if.i_pll_locked = 1'b1;
        repeat (10) tick();
        check("s1_hold", 32'(sup_if.o_rst_core), 32'h7);
        tick(); check("s1_rel0_a", 32'(sup_if.o_rst_core), 32'h6);
        tick(); check("s1_rel0_b", 32'(sup_if.o_rst_core), 32'h6);
        tick(); check("s1_rel1_a", 32'(sup_if.o_rst_core), 32'h4);
        tick(); check("s1_rel1_b", 32'(sup_if.o_rst_core), 32'h4);
        tick(); check("s1_rel2", 32'(sup_if.o_rst_core), 32'h0);
        check("s1_not_ready_yet", 32'(sup_if.o_ready), 0);
        tick(); check("s1_ready", 32'(sup_if.o_ready), 1);
        check("s1_state_run", 32'(sup_if.o_state), 3);

        // Lock loss in RUN: immediate reassert, one 4-cycle pulse, relock clears retry
        repeat (3) tick();
        sup_if.i_pll_locked = 1'b0;
        tick(); tick();
        check("s4_still_ready", 32'(sup_if.o_ready), 1);
        tick();
        check("s4_rst_core", 32'(sup_if.o_rst_core), 32'h7);
        check("s4_ready_low", 32'(sup_if.o_ready), 0);
        check("s4_pulse_on", 32'(sup_if.o_pll_stdy_rst), 1);
        check("s4_retry1", 32'(sup_if.o_retry_cnt), 1);
        repeat (3) tick();
        check("s4_pulse_last", 32'(sup_if.o_pll_stdy_rst), 1);
        tick();
        check("s4_pulse_off", 32'(sup_if.o_pll_stdy_rst), 0);
        check("s4_back_wait", 32'(sup_if.o_state), 0);
        sup_if.i_pll_locked = 1'b1;
        repeat (10) tick();
        check("s4_retry_kept", 32'(sup_if.o_retry_cnt), 1);
        repeat (10) tick();
        check("s4_ready_again", 32'(sup_if.o_ready), 1);
        check("s4_retry_cleared", 32'(sup_if.o_retry_cnt), 0);

        // One-cycle glitch while qualifying: no retry spent, qualification restarts
        rstn = 1'b0;
        sup_if.i_pll_locked = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        sup_if.i_pll_locked = 1'b1;
        repeat (5) tick();
        sup_if.i_pll_locked = 1'b0;
        tick();
        sup_if.i_pll_locked = 1'b1;
        n = 0;
        while (sup_if.o_rst_core[0] && n < 40) begin
            tick();
            n++;
        end
        check("s2_release_delay", 32'(n), 11);
        check("s2_retry_zero", 32'(sup_if.o_retry_cnt), 0);

        // No lock at all: three pulses on a 36-cycle period, then sticky fault
        rstn = 1'b0;
        sup_if.i_pll_locked = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (31) tick();
        check("s3_before_timeout", 32'(sup_if.o_pll_stdy_rst), 0);
        tick();
        check("s3_first_pulse", 32'(sup_if.o_pll_stdy_rst), 1);
        check("s3_first_retry", 32'(sup_if.o_retry_cnt), 1);
        hi = 1;
        repeat (122) begin
            tick();
            if (sup_if.o_pll_stdy_rst) hi++;
        end
        check("s3_pulse_cycles", 32'(hi), 12);
        check("s3_fault", 32'(sup_if.o_fault), 1);
        check("s3_retry3", 32'(sup_if.o_retry_cnt), 3);
        check("s3_rst_core", 32'(sup_if.o_rst_core), 32'h7);
        sup_if.i_pll_locked = 1'b1;
        repeat (20) tick();
        check("s3_fault_sticky", 32'(sup_if.o_fault), 1);
        check("s3_state_fault", 32'(sup_if.o_state), 5);

        // Reset pulse during FAULT, then during RELEASE
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("s5_fault_cleared", 32'(sup_if.o_fault), 0);
        check("s5_state_wait", 32'(sup_if.o_state), 0);
        check("s5_retry_zero", 32'(sup_if.o_retry_cnt), 0);
        check("s5_rst_core", 32'(sup_if.o_rst_core), 32'h7);
        n = 0;
        while (sup_if.o_rst_core == 3'b111 && n < 40) begin
            tick();
            n++;
        end
        check("s5_reached_release", 32'(sup_if.o_state), 2);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("s5_release_abort_state", 32'(sup_if.o_state), 0);
        check("s5_release_abort_rst", 32'(sup_if.o_rst_core), 32'h7);
        n = 0;
        while (!sup_if.o_ready && n < 40) begin
            tick();
            n++;
        end
        check("s5_ready_after_restart", 32'(sup_if.o_ready), 1);

        // Randomized lock traffic with occasional resets
        for (int seg = 0; seg < 120; seg++) begin
            sup_if.i_pll_locked = 1'($urandom_range(0, 3) != 0);
            len = sup_if.i_pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
            rstn = ($urandom_range(0, 19) != 0);
            tick();
            rstn = 1'b1;
            repeat (len) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
